fb_bank_arbiter: RTL and testbench

Controller for the shared LED frame-buffer RAM between the SPI write path and the WS2812 output engine. The buffer is split into two banks: the output engine reads the display bank while SPI writes fill the back bank. A small write FIFO absorbs SPI strobes while the RAM port is busy. Banks swap only at a frame boundary, so a frame is never displayed half-written.

---
 rtl/fb_bank_arbiter_pkg.sv | 21 ++
 rtl/fb_bank_arbiter_if.sv | 27 ++
 rtl/fb_bank_arbiter_write_fifo.sv | 49 ++++
 rtl/fb_bank_arbiter.sv | 107 ++++++++++
 tb/tb_fb_bank_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_bank_arbiter_pkg.sv
// Shared constants, FIFO entry layout and swap FSM encoding for the frame-buffer
// bank arbiter.
package fb_bank_arbiter_pkg;

   localparam int unsigned WORDS      = 1305;
   localparam int unsigned ADDR_W     = 13;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      StIdle,
      StPending,
      StSwap
   } swap_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/fb_bank_arbiter_if.sv
// SPI write bus, output-engine read bus and RAM port of the frame-buffer arbiter.
interface fb_bank_arbiter_if;
   import fb_bank_arbiter_pkg::*;

   logic [DATA_W-1:0] spi_data;
   logic [ADDR_W-1:0] spi_address;
   logic              spi_write_strobe;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_address;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  spi_data, spi_address, spi_write_strobe, rd_req, rd_address, mem_rdata,
      output rd_valid, rd_data, mem_address, mem_wdata, mem_we
   );

   modport master (
      output spi_data, spi_address, spi_write_strobe, rd_req, rd_address, mem_rdata,
      input  rd_valid, rd_data, mem_address, mem_wdata, mem_we
   );

endinterface

// File: rtl/fb_bank_arbiter_write_fifo.sv
// Synchronous write FIFO; a push while full is accepted only if a pop happens in
// the same cycle.
module fb_bank_arbiter_write_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 29
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [Width-1:0]         wdata,
   input  logic                     pop,
   output logic [Width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (PtrW+1)'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/fb_bank_arbiter.sv
// Frame-buffer RAM arbiter: reads from the display bank win the port, buffered SPI
// writes fill the back bank, and banks swap only at a frame boundary.
module fb_bank_arbiter
   import fb_bank_arbiter_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   fb_bank_arbiter_if.slave  bus,
   input  logic              spi_frame_done,
   input  logic              frame_start,
   output logic              active_bank,
   output logic              swap_pending,
   output logic              fifo_overflow
);

   wr_entry_t                     fifo_wdata, head;
   logic                          fifo_full, fifo_empty, fifo_pop, head_in_range;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   logic [ADDR_W:0]   mem_address_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_we_q, rd_pipe_q, rd_valid_q, overflow_q;
   logic              active_bank_q, active_bank_d;
   swap_state_e       state_q, state_d;

   assign fifo_wdata    = '{addr: bus.spi_address, data: bus.spi_data};
   assign fifo_pop      = !bus.rd_req && !fifo_empty;
   assign head_in_range = (head.addr < ADDR_W'(WORDS));

   fb_bank_arbiter_write_fifo #(
      .Depth (FIFO_DEPTH),
      .Width ($bits(wr_entry_t))
   ) u_write_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (bus.spi_write_strobe),
      .wdata   (fifo_wdata),
      .pop     (fifo_pop),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Out-of-range writes still pop their slot but leave the port untouched.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         rd_pipe_q     <= 1'b0;
         rd_valid_q    <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         if (bus.rd_req) begin
            mem_address_q <= {active_bank_q, bus.rd_address};
         end else if (fifo_pop && head_in_range) begin
            mem_address_q <= {~active_bank_q, head.addr};
            mem_wdata_q   <= head.data;
            mem_we_q      <= 1'b1;
         end
         rd_pipe_q  <= bus.rd_req;
         rd_valid_q <= rd_pipe_q;
         if (bus.spi_write_strobe && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         active_bank_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         active_bank_q <= active_bank_d;
      end
   end

   // Swap only when nothing is queued or arriving for the current back bank.
   always_comb begin
      state_d       = state_q;
      active_bank_d = active_bank_q;
      unique case (state_q)
         StIdle: begin
            if (spi_frame_done) state_d = StPending;
         end
         StPending: begin
            if (frame_start && (fifo_count == '0) && !bus.spi_write_strobe) state_d = StSwap;
         end
         StSwap: begin
            active_bank_d = ~active_bank_q;
            state_d       = spi_frame_done ? StPending : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.mem_address = mem_address_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_valid_q ? bus.mem_rdata : '0;
   assign active_bank     = active_bank_q;
   assign swap_pending    = (state_q != StIdle);
   assign fifo_overflow   = overflow_q;

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Directed bench for fb_bank_arbiter: port timing, arbitration, overflow, bank swap
// and asynchronous reset, against hand-computed values.
module tb_fb_bank_arbiter;

   logic clock;
   logic reset_n;
   logic spi_frame_done;
   logic frame_start;
   logic active_bank;
   logic swap_pending;
   logic fifo_overflow;

   int n_checks = 0;
   int n_errors = 0;

   fb_bank_arbiter_if bus ();

   fb_bank_arbiter dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .bus            (bus),
      .spi_frame_done (spi_frame_done),
      .frame_start    (frame_start),
      .active_bank    (active_bank),
      .swap_pending   (swap_pending),
      .fifo_overflow  (fifo_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM stand-in: registered data is a fixed pattern of the presented address.
   always @(posedge clock) bus.mem_rdata <= 16'hC000 | {2'b00, bus.mem_address};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_port(input string tag, input logic we, input logic [13:0] addr,
                             input logic [15:0] wdata);
      check_eq({tag, "_we"}, 32'(bus.mem_we), 32'(we));
      check_eq({tag, "_addr"}, 32'(bus.mem_address), 32'(addr));
      check_eq({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(wdata));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n              = 1'b0;
      spi_frame_done       = 1'b0;
      frame_start          = 1'b0;
      bus.spi_data         = '0;
      bus.spi_address      = '0;
      bus.spi_write_strobe = 1'b0;
      bus.rd_req           = 1'b0;
      bus.rd_address       = '0;
      tick();
      tick();

      // Reset state
      check_port("rst", 1'b0, 14'h0000, 16'h0000);
      check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
      check_eq("rst_rd_data", 32'(bus.rd_data), 0);
      check_eq("rst_active_bank", 32'(active_bank), 0);
      check_eq("rst_swap_pending", 32'(swap_pending), 0);
      check_eq("rst_overflow", 32'(fifo_overflow), 0);
      reset_n = 1'b1;
      tick();

      // Single write: port shows it two cycles after the strobe, in back bank 1
      bus.spi_write_strobe = 1'b1;
      bus.spi_address      = 13'd5;
      bus.spi_data         = 16'hABCD;
      tick();
      bus.spi_write_strobe = 1'b0;
      check_eq("wr_n1_we", 32'(bus.mem_we), 0);
      tick();
      check_port("wr_n2", 1'b1, 14'h2005, 16'hABCD);

      // Out-of-range write is discarded at dequeue
      bus.spi_write_strobe = 1'b1;
      bus.spi_address      = 13'd1305;
      bus.spi_data         = 16'hFFFF;
      tick();
      bus.spi_write_strobe = 1'b0;
      tick();
      check_port("oor", 1'b0, 14'h2005, 16'hABCD);

      // Read beats a queued write; write follows the next cycle
      bus.spi_write_strobe = 1'b1;
      bus.spi_address      = 13'h010;
      bus.spi_data         = 16'h1111;
      tick();
      bus.spi_write_strobe = 1'b0;
      bus.rd_req           = 1'b1;
      bus.rd_address       = 13'd7;
      tick();
      bus.rd_req = 1'b0;
      check_eq("arb_rd_we", 32'(bus.mem_we), 0);
      check_eq("arb_rd_addr", 32'(bus.mem_address), 32'h0007);
      tick();
      check_port("arb_wr", 1'b1, 14'h2010, 16'h1111);
      check_eq("arb_rd_valid", 32'(bus.rd_valid), 1);
      check_eq("arb_rd_data", 32'(bus.rd_data), 32'hC007);
      tick();
      check_eq("arb_idle_valid", 32'(bus.rd_valid), 0);
      check_eq("arb_idle_we", 32'(bus.mem_we), 0);

      // Five strobes under continuous reads: fifth dropped, first four drain later
      for (int i = 0; i < 5; i++) begin
         bus.spi_write_strobe = 1'b1;
         bus.spi_address      = 13'(32'h20 + i);
         bus.spi_data         = 16'(32'h3000 + i);
         bus.rd_req           = 1'b1;
         bus.rd_address       = 13'(i);
         tick();
         check_eq("ovf_rd_we", 32'(bus.mem_we), 0);
         check_eq("ovf_rd_addr", 32'(bus.mem_address), 32'(i));
      end
      bus.spi_write_strobe = 1'b0;
      bus.rd_req           = 1'b0;
      check_eq("ovf_flag", 32'(fifo_overflow), 1);
      check_eq("ovf_rd_valid", 32'(bus.rd_valid), 1);
      check_eq("ovf_rd_data", 32'(bus.rd_data), 32'hC003);
      for (int j = 0; j < 4; j++) begin
         tick();
         check_port("ovf_drain", 1'b1, 14'(32'h2020 + j), 16'(32'h3000 + j));
      end
      tick();
      check_eq("ovf_drained_we", 32'(bus.mem_we), 0);
      check_eq("ovf_sticky", 32'(fifo_overflow), 1);

      // Swap with an empty FIFO
      spi_frame_done = 1'b1;
      tick();
      spi_frame_done = 1'b0;
      check_eq("sw_pending", 32'(swap_pending), 1);
      check_eq("sw_bank_before", 32'(active_bank), 0);
      tick();
      frame_start = 1'b1;
      tick();
      frame_start    = 1'b0;
      check_eq("sw_n1_bank", 32'(active_bank), 0);
      check_eq("sw_n1_pending", 32'(swap_pending), 1);
      bus.rd_req     = 1'b1;
      bus.rd_address = 13'd3;
      tick();
      bus.rd_req = 1'b0;
      check_eq("sw_n2_bank", 32'(active_bank), 1);
      check_eq("sw_n2_pending", 32'(swap_pending), 0);
      check_eq("sw_old_bank_rd", 32'(bus.mem_address), 32'h0003);
      bus.spi_write_strobe = 1'b1;
      bus.spi_address      = 13'd9;
      bus.spi_data         = 16'h9999;
      tick();
      bus.spi_write_strobe = 1'b0;
      tick();
      check_port("sw_wr_bank0", 1'b1, 14'h0009, 16'h9999);

      // Reset during a pending swap with queued writes and reads in flight
      spi_frame_done       = 1'b1;
      bus.spi_write_strobe = 1'b1;
      bus.spi_address      = 13'h040;
      bus.spi_data         = 16'h4040;
      bus.rd_req           = 1'b1;
      bus.rd_address       = 13'd1;
      tick();
      spi_frame_done  = 1'b0;
      bus.spi_address = 13'h041;
      bus.spi_data    = 16'h4041;
      check_eq("mr_pending", 32'(swap_pending), 1);
      tick();
      bus.spi_write_strobe = 1'b0;
      bus.rd_req           = 1'b0;
      check_eq("mr_valid_before", 32'(bus.rd_valid), 1);
      reset_n = 1'b0;
      #1;
      check_eq("mr_bank", 32'(active_bank), 0);
      check_eq("mr_pending_clr", 32'(swap_pending), 0);
      check_eq("mr_valid_clr", 32'(bus.rd_valid), 0);
      check_eq("mr_overflow_clr", 32'(fifo_overflow), 0);
      check_eq("mr_we", 32'(bus.mem_we), 0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("mr_fifo_empty_we", 32'(bus.mem_we), 0);
      end

      // Swap deferred while the FIFO holds two entries, taken on the next frame
      spi_frame_done       = 1'b1;
      bus.spi_write_strobe = 1'b1;
      bus.spi_address      = 13'h030;
      bus.spi_data         = 16'h5030;
      bus.rd_req           = 1'b1;
      bus.rd_address       = 13'd2;
      tick();
      spi_frame_done  = 1'b0;
      bus.spi_address = 13'h031;
      bus.spi_data    = 16'h5031;
      tick();
      bus.spi_write_strobe = 1'b0;
      frame_start          = 1'b1;
      tick();
      bus.rd_req  = 1'b0;
      frame_start = 1'b0;
      check_eq("df_pending", 32'(swap_pending), 1);
      check_eq("df_bank", 32'(active_bank), 0);
      tick();
      check_port("df_drain0", 1'b1, 14'h2030, 16'h5030);
      tick();
      check_port("df_drain1", 1'b1, 14'h2031, 16'h5031);
      check_eq("df_no_swap", 32'(active_bank), 0);
      check_eq("df_still_pending", 32'(swap_pending), 1);
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_eq("df_n1_bank", 32'(active_bank), 0);
      tick();
      check_eq("df_n2_bank", 32'(active_bank), 1);
      check_eq("df_n2_pending", 32'(swap_pending), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
